// File: rtl/snn_seq_pkg.sv
// Shared types and default constants for the SNN frame sequencer.
package snn_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SETTLE,
      S_TICK,
      S_RUN,
      S_DONE
   } seq_state_t;

   localparam int SNN_NUM_OUTPUT     = 250;
   localparam int SNN_PKT_W          = 30;
   localparam int SNN_CNT_W          = 7;
   localparam int SNN_SETTLE_CYCLES  = 1000;
   localparam int SNN_TIMEOUT_CYCLES = 70000;

endpackage

// File: rtl/snn_spike_collector.sv
// Collects core output spike packets into a per-neuron bit vector.
// Packet index p maps to bit NUM_OUTPUT-1-p; indices >= NUM_OUTPUT are dropped.
module snn_spike_collector
   import snn_seq_pkg::*;
#(
   parameter int NUM_OUTPUT = SNN_NUM_OUTPUT  // must be <= 256 (8-bit packet index)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clear_i,
   input  logic                  en_i,
   input  logic [7:0]            packet_out,
   input  logic                  packet_out_valid,
   output logic [NUM_OUTPUT-1:0] spike_vec_o
);

   logic                  in_range;
   logic [NUM_OUTPUT-1:0] hit;
   logic [NUM_OUTPUT-1:0] vec_q, vec_d;

   assign in_range = ({24'd0, packet_out} < 32'(NUM_OUTPUT));

   for (genvar i = 0; i < NUM_OUTPUT; i++) begin : g_bit
      assign hit[i] = en_i & packet_out_valid & in_range &
                      (packet_out == 8'(NUM_OUTPUT - 1 - i));
   end

   always_comb begin
      vec_d = vec_q | hit;
      if (clear_i) vec_d = '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) vec_q <= '0;
      else          vec_q <= vec_d;
   end

   assign spike_vec_o = vec_q;

endmodule

// File: rtl/snn_frame_sequencer.sv
// Per-frame controller: load packets into the core FIFO, settle, tick,
// collect output spikes until the core goes idle again or times out.
module snn_frame_sequencer
   import snn_seq_pkg::*;
#(
   parameter int NUM_OUTPUT     = SNN_NUM_OUTPUT,
   parameter int PKT_W          = SNN_PKT_W,
   parameter int CNT_W          = SNN_CNT_W,
   parameter int SETTLE_CYCLES  = SNN_SETTLE_CYCLES,
   parameter int TIMEOUT_CYCLES = SNN_TIMEOUT_CYCLES
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [CNT_W-1:0]      num_packets,
   input  logic                  src_valid,
   input  logic [PKT_W-1:0]      src_data,
   output logic                  src_ready,
   output logic                  packet_winc,
   output logic [PKT_W-1:0]      packet_wdata,
   input  logic                  packet_wfull,
   output logic                  tick,
   input  logic                  core_idle,
   input  logic [7:0]            packet_out,
   input  logic                  packet_out_valid,
   output logic                  busy,
   output logic [NUM_OUTPUT-1:0] spike_vec,
   output logic                  result_valid,
   output logic                  timeout_err
);

   localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
   localparam int RUN_W = $clog2(TIMEOUT_CYCLES + 1);

   seq_state_t       state_q, state_d;
   logic [CNT_W-1:0] remaining_q, remaining_d;
   logic [SET_W-1:0] settle_q, settle_d;
   logic [RUN_W-1:0] run_q, run_d;
   logic             seen_busy_q, seen_busy_d;
   logic             to_flag_q, to_flag_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         remaining_q <= '0;
         settle_q    <= '0;
         run_q       <= '0;
         seen_busy_q <= 1'b0;
         to_flag_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         settle_q    <= settle_d;
         run_q       <= run_d;
         seen_busy_q <= seen_busy_d;
         to_flag_q   <= to_flag_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      remaining_d  = remaining_q;
      settle_d     = settle_q;
      run_d        = run_q;
      seen_busy_d  = seen_busy_q;
      to_flag_d    = to_flag_q;
      src_ready    = 1'b0;
      packet_winc  = 1'b0;
      packet_wdata = '0;
      tick         = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               remaining_d = num_packets;
               settle_d    = '0;
               state_d     = (num_packets != '0) ? S_LOAD : S_SETTLE;
            end
         end
         S_LOAD: begin
            src_ready    = !packet_wfull;
            packet_winc  = src_valid & !packet_wfull;
            packet_wdata = src_data;
            if (packet_winc && remaining_q != '0) begin
               remaining_d = remaining_q - CNT_W'(1);
               if (remaining_q == CNT_W'(1)) begin
                  settle_d = '0;
                  state_d  = S_SETTLE;
               end
            end
         end
         S_SETTLE: begin
            if (settle_q == SET_W'(SETTLE_CYCLES - 1)) state_d = S_TICK;
            else                                        settle_d = settle_q + SET_W'(1);
         end
         S_TICK: begin
            tick        = 1'b1;
            run_d       = '0;
            seen_busy_d = 1'b0;
            to_flag_d   = 1'b0;
            state_d     = S_RUN;
         end
         S_RUN: begin
            if (!core_idle) seen_busy_d = 1'b1;
            // A genuine completion wins over a timeout landing in the same cycle.
            if (seen_busy_q && core_idle) begin
               state_d = S_DONE;
            end else if (run_q == RUN_W'(TIMEOUT_CYCLES - 1)) begin
               to_flag_d = 1'b1;
               state_d   = S_DONE;
            end else begin
               run_d = run_q + RUN_W'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign busy         = (state_q != S_IDLE);
   assign result_valid = (state_q == S_DONE);
   assign timeout_err  = (state_q == S_DONE) & to_flag_q;

   // Clearing on entry to TICK makes the vector read zero during the tick cycle.
   snn_spike_collector #(.NUM_OUTPUT(NUM_OUTPUT)) u_collector (
      .clk              (clk),
      .reset_n          (reset_n),
      .clear_i          (state_d == S_TICK),
      .en_i             (state_q == S_RUN),
      .packet_out       (packet_out),
      .packet_out_valid (packet_out_valid),
      .spike_vec_o      (spike_vec)
   );

endmodule
